// File: rtl/antirebote_multi.sv
`default_nettype none
// ============================================================================
//  Module      : antirebote_multi
//  Description : N-channel button debouncer. Each channel has a two-flop
//                synchroniser, a stability counter that accepts a new level
//                only after LIMITE consecutive mismatching cycles, one-cycle
//                rise/fall pulses and a long-press flag raised after the
//                filtered level has stayed high for LARGO cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module antirebote_multi #(
    parameter int N      = 4,
    parameter int LIMITE = 50000,
    parameter int CW     = 16,
    parameter int LARGO  = 100000000,
    parameter int LW     = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_out,
    output logic [N-1:0] sube,
    output logic [N-1:0] baja,
    output logic [N-1:0] largo
);

    // Terminal counts; counters stop here so they never wrap.
    localparam logic [CW-1:0] c_lim_m1   = CW'(LIMITE - 1);
    localparam logic [LW-1:0] c_largo_m1 = LW'(LARGO - 1);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic [CW-1:0] r_cnt;
            logic [LW-1:0] r_lc;
            logic          r_out;
            logic          r_sube;
            logic          r_baja;
            logic          r_largo;
            logic          w_accept;
            logic          w_out_next;

            // A new level is accepted on the LIMITE-th consecutive mismatch.
            assign w_accept   = (r_s2[gi] != r_out) && (r_cnt == c_lim_m1);
            assign w_out_next = w_accept ? r_s2[gi] : r_out;

            // Stability counter, filtered level and edge pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_out  <= 1'b0;
                    r_sube <= 1'b0;
                    r_baja <= 1'b0;
                end else begin
                    r_sube <= 1'b0;
                    r_baja <= 1'b0;
                    if (r_s2[gi] == r_out) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_out  <= r_s2[gi];
                        r_cnt  <= '0;
                        r_sube <= r_s2[gi];
                        r_baja <= ~r_s2[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Long-press timer; cleared using the next level so the flag
            // drops on the same edge as the filtered output falls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lc    <= '0;
                    r_largo <= 1'b0;
                end else if (!w_out_next) begin
                    r_lc    <= '0;
                    r_largo <= 1'b0;
                end else if (r_out) begin
                    if (r_lc == c_largo_m1) begin
                        r_largo <= 1'b1;
                    end else begin
                        r_lc <= r_lc + 1'b1;
                    end
                end
            end

            assign btn_out[gi] = r_out;
            assign sube[gi]    = r_sube;
            assign baja[gi]    = r_baja;
            assign largo[gi]   = r_largo;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_antirebote_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_antirebote_multi
//  Description : Self-checking bench for antirebote_multi (N=2, LIMITE=4,
//                LARGO=10). A history-based reference model predicts all
//                outputs every cycle; directed steps check the key latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_antirebote_multi;

    localparam int N      = 2;
    localparam int LIMITE = 4;
    localparam int CW     = 3;
    localparam int LARGO  = 10;
    localparam int LW     = 4;
    localparam int HMAX   = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_out;
    logic [N-1:0] sube;
    logic [N-1:0] baja;
    logic [N-1:0] largo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    antirebote_multi #(
        .N(N), .LIMITE(LIMITE), .CW(CW), .LARGO(LARGO), .LW(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_out(btn_out),
        .sube(sube),
        .baja(baja),
        .largo(largo)
    );

    // Reference model: the raw input sampled at every edge since reset is
    // kept; the synchronised value at edge e is the sample from edge e-2.
    // A channel flips when the synchronised value differed from the output
    // on each of the last LIMITE edges.
    bit           hist [N][HMAX];
    int           k;
    int           rise_k [N];
    logic [N-1:0] m_out, m_sube, m_baja, m_largo;

    function automatic bit s2_at(input int ch, input int e);
        return (e >= 2) ? hist[ch][e-2] : 1'b0;
    endfunction

    task automatic model_reset();
        k       = 0;
        m_out   = '0;
        m_sube  = '0;
        m_baja  = '0;
        m_largo = '0;
        for (int ch = 0; ch < N; ch++) rise_k[ch] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] v);
        for (int ch = 0; ch < N; ch++) hist[ch][k] = v[ch];
        for (int ch = 0; ch < N; ch++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 0; j < LIMITE; j++) begin
                if (k - j < 0) flip = 1'b0;
                else if (s2_at(ch, k - j) == m_out[ch]) flip = 1'b0;
            end
            m_sube[ch] = flip && !m_out[ch];
            m_baja[ch] = flip && m_out[ch];
            if (flip) begin
                m_out[ch] = ~m_out[ch];
                if (m_out[ch]) rise_k[ch] = k;
            end
            m_largo[ch] = m_out[ch] && ((k - rise_k[ch]) >= LARGO);
        end
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, compare at the falling edge.
    task automatic tick(input logic [N-1:0] v);
        btn_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        chk("btn_out", 32'(btn_out), 32'(m_out));
        chk("sube",    32'(sube),    32'(m_sube));
        chk("baja",    32'(baja),    32'(m_baja));
        chk("largo",   32'(largo),   32'(m_largo));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"},   32'(btn_out), 0);
        chk({tag, "_sube"},  32'(sube),    0);
        chk({tag, "_baja"},  32'(baja),    0);
        chk({tag, "_largo"}, 32'(largo),   0);
    endtask

    // Asynchronous reset pulse issued mid-cycle; released at a falling edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 chk_zero("rst_now");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int t_a, t_b;
        logic [N-1:0] cur, v;

        // 1. Reset values and first acceptance after reset.
        rst    = 1'b1;
        btn_in = 2'b11;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) tick(2'b11);
        chk("rst_lat_before", 32'(btn_out), 0);
        tick(2'b11);
        chk("rst_lat_out",  32'(btn_out), 3);
        chk("rst_lat_sube", 32'(sube),    3);
        tick(2'b11);
        chk("rst_sube_width", 32'(sube), 0);
        for (int i = 0; i < 8; i++) tick(2'b00);
        chk("release_all", 32'(btn_out), 0);

        // 2. Glitch rejection on channel 0.
        for (int i = 0; i < 3; i++) tick(2'b01);
        tick(2'b00);
        for (int i = 0; i < 3; i++) tick(2'b01);
        for (int i = 0; i < 8; i++) begin
            tick(2'b00);
            chk("glitch_out", 32'(btn_out[0]), 0);
        end

        // 3. Clean press and release on channel 0.
        for (int i = 0; i < 5; i++) tick(2'b01);
        chk("press_before", 32'(btn_out), 0);
        tick(2'b01);
        chk("press_out",  32'(btn_out), 1);
        chk("press_sube", 32'(sube),    1);
        tick(2'b01);
        chk("press_sube_end", 32'(sube), 0);
        for (int i = 0; i < 5; i++) tick(2'b00);
        chk("rel_before", 32'(btn_out), 1);
        tick(2'b00);
        chk("rel_out",  32'(btn_out), 0);
        chk("rel_baja", 32'(baja),    1);
        for (int i = 0; i < 4; i++) tick(2'b00);

        // 4. Long press on channel 1.
        t_a = -1;
        t_b = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(2'b10);
            if (t_a < 0 && btn_out[1]) t_a = i;
            if (t_b < 0 && largo[1])   t_b = i;
        end
        chk("lp_out_rise",   32'(t_a), 6);
        chk("lp_largo_rise", 32'(t_b), 16);
        t_a = -1;
        t_b = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(2'b00);
            if (t_a < 0 && !btn_out[1]) t_a = i;
            if (t_b < 0 && !largo[1])   t_b = i;
        end
        chk("lp_out_fall",   32'(t_a), 6);
        chk("lp_largo_fall", 32'(t_b), 6);

        // 5. Both channels change together.
        for (int i = 0; i < 5; i++) tick(2'b11);
        tick(2'b11);
        chk("sim_out_rise", 32'(btn_out), 3);
        chk("sim_sube",     32'(sube),    3);
        for (int i = 0; i < 5; i++) tick(2'b00);
        tick(2'b00);
        chk("sim_out_fall", 32'(btn_out), 0);
        chk("sim_baja",     32'(baja),    3);

        // 6. Reset while the counters are part-way through a rise.
        for (int i = 0; i < 4; i++) tick(2'b11);
        async_reset();
        for (int i = 0; i < 5; i++) tick(2'b11);
        chk("mid_rst_before", 32'(btn_out), 0);
        tick(2'b11);
        chk("mid_rst_out",  32'(btn_out), 3);
        chk("mid_rst_sube", 32'(sube),    3);

        // 7. Random bouncing against the model, with one reset in the middle.
        cur = 2'b11;
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 24) == 0) cur[ch] = ~cur[ch];
            v = cur;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 11) == 0) v[ch] = ~v[ch];
            tick(v);
            if (i == 200) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/antirebote_multi.md
# antirebote_multi

Parametrised N-channel debouncer with input synchronisation, per-channel edge pulses and long-press detection. Sits between raw board buttons/switches and the control logic. It replaces single-channel debounce instances with one block serving a whole button bank. Each channel is fully independent and shares only clock and reset.

## Interface

- `N`, 4, number of channels (≥1)
- `LIMITE`, 50000, consecutive stable cycles required to accept a new level (≥1; 0.5 ms at 100 MHz)
- `CW`, 16, debounce counter width; must satisfy 2^CW > LIMITE
- `LARGO`, 100000000, cycles `btn_out[i]` must stay high before `largo[i]` asserts (≥1; 1 s at 100 MHz)
- `LW`, 27, long-press counter width; must satisfy 2^LW > LARGO

- `clk` in 1 — single system clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `btn_in` in N — raw unstable inputs, asynchronous to `clk`
- `btn_out` out N — filtered levels
- `sube` out N — one-cycle pulse when `btn_out[i]` rises 0→1
- `baja` out N — one-cycle pulse when `btn_out[i]` falls 1→0
- `largo` out N — level, high while the channel is in long-press

Reset behaviour: `rst` is asynchronous and active-high. While `rst`=1, every register, output and counter is 0.

## Operation

- **Synchroniser.** Each channel has two flops: `s1[i] <= btn_in[i]`, then `s2[i] <= s1[i]`. Only `s2` is used downstream.
- **Debounce counter `cnt[i]` (CW bits).**
  - If `s2[i] == btn_out[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == LIMITE-1`: `btn_out[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - Any single-cycle return of `s2` to the `btn_out` level restarts the count from 0. The count never wraps, because it caps at `LIMITE-1`.
- **Edge pulses.** `sube[i]` and `baja[i]` are registered. They are high exactly during the cycle in which `btn_out[i]` holds its new value, i.e. they are set on the same edge that updates `btn_out[i]` and cleared on the next edge.
- **Long-press counter `lc[i]` (LW bits).**
  - If `btn_out[i]==0`: `lc[i] <= 0` and `largo[i] <= 0`.
  - Else if `lc[i] == LARGO-1`: `largo[i] <= 1` and `lc[i]` holds (saturates, no wrap).
  - Else: `lc[i] <= lc[i]+1`.
- **Per-channel states (implicit):**
  - IDLE (`out`=0)
  - PRESSED (`out`=1, `largo`=0)
  - LONG (`out`=1, `largo`=1)
  - Transitions: IDLE→PRESSED on accepted rise; PRESSED→LONG after LARGO cycles; PRESSED/LONG→IDLE on accepted fall.
- **Simultaneous events.** Channels never interact. Several channels may pulse in the same cycle.
- **Reset mid-operation.** All counts, flags and pulses clear immediately. After release, a held button is re-debounced from scratch and produces a fresh `sube`.

## Timing

- **Debounce latency.** `btn_in` changes and is stable before edge k.
  - `s2` reflects it after edge k+1.
  - `btn_out` updates at edge k+1+LIMITE.
  - Total: LIMITE+2 cycles from input change to output.
- **Pulse width.** `sube` and `baja` are exactly 1 cycle, coincident with the first cycle of the new `btn_out` level.
- **Long-press timing.** `largo` rises LARGO cycles after `btn_out` rises, i.e. at the LARGO-th rising edge after the `btn_out` update edge. `largo` falls on the same edge that `btn_out` falls.
- **LIMITE=1.** Output follows `s2` with 1 cycle of delay; pulses still occur.
- **Glitch rejection.** A mismatch of LIMITE-1 cycles or fewer never changes `btn_out`.

## Test plan

Bench parameters: N=2, LIMITE=4, LARGO=10.

1. **Reset values.** Assert `rst` with `btn_in`=2'b11 → all outputs 0 during reset. Release reset → `btn_out[1:0]`=2'b11 exactly 6 cycles later, with `sube`=2'b11 for one cycle.
2. **Glitch rejection.** Pulse `btn_in[0]` high for 3 cycles, low for 1, high for 3 → `btn_out[0]` stays 0, and `sube`/`baja` stay 0.
3. **Clean press and release.** Hold `btn_in[0]`=1 → `btn_out[0]` rises at cycle +6 with a 1-cycle `sube[0]`. Release → `btn_out[0]` falls at +6 with a 1-cycle `baja[0]`. `btn_out[1]` is unaffected throughout.
4. **Long press.** Hold `btn_in[1]`=1 for 30 cycles → `largo[1]` rises 10 cycles after `btn_out[1]`. Release → `largo[1]` and `btn_out[1]` fall on the same edge.
5. **Simultaneous channels.** Change both inputs on the same cycle → both `btn_out` bits and both pulses toggle in the same cycle.
6. **Reset mid-count.** Assert `rst` asynchronously while `cnt`=2 on a rising input → outputs remain 0. After release, the full 6-cycle latency applies again.
